// File: rtl/matmul_seq_ctrl.sv
// Job sequencer for the 3x3 4-bit matrix multiplier: buffers host W/X elements, clears and loads the bank, unloads results.
// Optional macro MATMUL_DIM_CHECK_EN: reject jobs with a zero dimension or col_w != row_x.
module matmul_seq_ctrl #(
    parameter int unsigned DATA_W       = 4,
    parameter int unsigned RES_W        = 10,
    parameter int unsigned DRAIN_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 clear_n,
    input  logic                 start,
    input  logic [1:0]           row_w,
    input  logic [1:0]           col_w,
    input  logic [1:0]           row_x,
    input  logic [1:0]           col_x,
    input  logic                 in_valid,
    input  logic [DATA_W-1:0]    in_data,
    output logic                 in_ready,
    output logic                 clear_mem,
    output logic [DATA_W-1:0]    mem_data_in,
    input  logic                 unload_res,
    input  logic [9*RES_W-1:0]   res_flat,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [RES_W-1:0]     out_data,
    output logic [1:0]           out_row,
    output logic [1:0]           out_col,
    output logic                 out_last,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam int unsigned CNT_W = $clog2(DRAIN_CYCLES + 1);
    localparam int unsigned BUF_N = 18;
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CHECK,
        S_COLLECT,
        S_CLEAR,
        S_STREAM,
        S_WAIT_BANK,
        S_DRAIN,
        S_UNLOAD,
        S_FINISH
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         rw_q, rw_d, cw_q, cw_d, rx_q, rx_d, cx_q, cx_d;
    logic [4:0]         ntot_q, ntot_d;
    logic [4:0]         k_q, k_d;
    logic               in_ready_q, in_ready_d;
    logic [CNT_W-1:0]   drain_q, drain_d;
    logic [1:0]         r_q, r_d, c_q, c_d;
    logic               elem_we, snap_we;

    logic [DATA_W-1:0]  elem_q [BUF_N];
    logic [RES_W-1:0]   snap_q [9];

    logic [3:0]         n_w, n_x;
    logic [4:0]         n_tot;
    logic [3:0]         res_idx;
    logic               has_out, last_word;

    assign n_w       = {2'b00, rw_q} * {2'b00, cw_q};
    assign n_x       = {2'b00, rx_q} * {2'b00, cx_q};
    assign n_tot     = {1'b0, n_w} + {1'b0, n_x};
    assign res_idx   = {2'b00, r_q} * 4'd3 + {2'b00, c_q};
    assign has_out   = (rw_q != 2'd0) && (cx_q != 2'd0);
    assign last_word = (r_q == rw_q - 2'd1) && (c_q == cx_q - 2'd1);

`ifdef MATMUL_DIM_CHECK_EN
    logic err_q, err_d;
    logic dims_bad;

    assign dims_bad = (rw_q == 2'd0) || (cw_q == 2'd0) || (rx_q == 2'd0) ||
                      (cx_q == 2'd0) || (cw_q != rx_q);
`endif

    always_comb begin
        state_d    = state_q;
        rw_d       = rw_q;
        cw_d       = cw_q;
        rx_d       = rx_q;
        cx_d       = cx_q;
        ntot_d     = ntot_q;
        k_d        = k_q;
        in_ready_d = in_ready_q;
        drain_d    = drain_q;
        r_d        = r_q;
        c_d        = c_q;
        elem_we    = 1'b0;
        snap_we    = 1'b0;
`ifdef MATMUL_DIM_CHECK_EN
        err_d      = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CHECK;
                    rw_d    = row_w;
                    cw_d    = col_w;
                    rx_d    = row_x;
                    cx_d    = col_x;
                end
            end
            S_CHECK: begin
                ntot_d     = n_tot;
                k_d        = '0;
                state_d    = S_COLLECT;
                in_ready_d = (n_tot != 5'd0);
`ifdef MATMUL_DIM_CHECK_EN
                if (dims_bad) begin
                    state_d    = S_IDLE;
                    in_ready_d = 1'b0;
                    err_d      = 1'b1;
                end
`endif
            end
            S_COLLECT: begin
                // in_ready is registered, so it must fall on the edge that takes the last element
                if (in_valid && in_ready_q) begin
                    elem_we = 1'b1;
                    k_d     = k_q + 5'd1;
                    if (k_q + 5'd1 == ntot_q) in_ready_d = 1'b0;
                end
                if (k_q == ntot_q) begin
                    state_d = S_CLEAR;
                    k_d     = '0;
                end
            end
            S_CLEAR: begin
                state_d = S_STREAM;
            end
            S_STREAM: begin
                k_d = k_q + 5'd1;
                if (k_q + 5'd1 >= ntot_q) begin
                    state_d = S_WAIT_BANK;
                    k_d     = '0;
                end
            end
            S_WAIT_BANK: begin
                if (unload_res) begin
                    state_d = S_DRAIN;
                    drain_d = '0;
                end
            end
            S_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    snap_we = 1'b1;
                    state_d = S_UNLOAD;
                    r_d     = '0;
                    c_d     = '0;
                end else begin
                    drain_d = drain_q + CNT_W'(1);
                end
            end
            S_UNLOAD: begin
                if (!has_out) begin
                    state_d = S_FINISH;
                end else if (out_ready) begin
                    if (last_word) begin
                        state_d = S_FINISH;
                    end else if (c_q == cx_q - 2'd1) begin
                        c_d = '0;
                        r_d = r_q + 2'd1;
                    end else begin
                        c_d = c_q + 2'd1;
                    end
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q    <= S_IDLE;
            rw_q       <= '0;
            cw_q       <= '0;
            rx_q       <= '0;
            cx_q       <= '0;
            ntot_q     <= '0;
            k_q        <= '0;
            in_ready_q <= 1'b0;
            drain_q    <= '0;
            r_q        <= '0;
            c_q        <= '0;
        end else begin
            state_q    <= state_d;
            rw_q       <= rw_d;
            cw_q       <= cw_d;
            rx_q       <= rx_d;
            cx_q       <= cx_d;
            ntot_q     <= ntot_d;
            k_q        <= k_d;
            in_ready_q <= in_ready_d;
            drain_q    <= drain_d;
            r_q        <= r_d;
            c_q        <= c_d;
        end
    end

`ifdef MATMUL_DIM_CHECK_EN
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) err_q <= 1'b0;
        else          err_q <= err_d;
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Element buffer and result snapshot carry no reset; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (elem_we) elem_q[k_q] <= in_data;
        if (snap_we) begin
            for (int unsigned i = 0; i < 9; i++) snap_q[i] <= res_flat[i*RES_W +: RES_W];
        end
    end

    assign in_ready    = in_ready_q;
    assign clear_mem   = ~clear_n | (state_q == S_CLEAR);
    assign mem_data_in = ((state_q == S_STREAM) && (k_q < ntot_q)) ? elem_q[k_q] : '0;
    assign out_valid   = (state_q == S_UNLOAD) && has_out;
    assign out_data    = out_valid ? snap_q[res_idx] : '0;
    assign out_row     = out_valid ? r_q : '0;
    assign out_col     = out_valid ? c_q : '0;
    assign out_last    = out_valid && last_word;
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_FINISH);

endmodule

// File: doc/matmul_seq_ctrl.md
Name: matmul_seq_ctrl

Overview:
Top-level sequencer for the 3x3 4-bit matrix multiplier. It accepts the W and X element streams from the host through a valid/ready handshake and buffers them. It clears the memory bank, then replays the buffer into the bank at one element per clock. It waits for the bank's unload_res plus the systolic drain, and returns the product row-major through a second valid/ready handshake.

Parameters:
DATA_W, 4, width of one input matrix element
RES_W, 10, width of one MAC result (8-bit product plus 2 accumulation bits)
DRAIN_CYCLES, 4, cycles waited after unload_res before results are sampled

Ports:
clk  input  1  clock; all state updates on rising edge
clear_n  input  1  asynchronous active-low reset
start  input  1  begin job; sampled only in IDLE
row_w  input  2  rows of W
col_w  input  2  columns of W
row_x  input  2  rows of X
col_x  input  2  columns of X
in_valid  input  1  host element valid
in_data  input  DATA_W  host element; all W row-major, then all X row-major
in_ready  output  1  controller accepts element
clear_mem  output  1  clear pulse to memory bank
mem_data_in  output  DATA_W  element stream to memory bank
unload_res  input  1  memory bank: all operands shifted into MAC array
res_flat  input  9*RES_W  MAC results; result (r,c) at slice index r*3+c
out_valid  output  1  result word valid
out_ready  input  1  host accepts result
out_data  output  RES_W  result word
out_row  output  2  row index of out_data
out_col  output  2  column index of out_data
out_last  output  1  final result word of job
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse on job completion
err  output  1  one-cycle pulse on rejected job

Behaviour:
- Reset (clear_n=0, asynchronous): state goes to IDLE.
  - All outputs are 0, except clear_mem=1 while reset is held, so the bank is flushed.
  - Buffer contents are don't-care.
  - Reset mid-job abandons the job with no done or err.
- States: IDLE, CHECK, COLLECT, CLEAR, STREAM, WAIT_BANK, DRAIN, UNLOAD, FINISH.
- IDLE → CHECK: on start=1. The four dimensions are latched. start while busy is ignored.
- CHECK (1 cycle): computes n_w=row_w*col_w and n_x=row_x*col_x as 4-bit values.
  - Goes to COLLECT, or to IDLE with err pulse (see Optional Feature).
- COLLECT:
  - in_ready=1.
  - Each in_valid&in_ready handshake writes in_data to buf[k], then k increments.
  - Exit to CLEAR the cycle after k reaches n_w+n_x (max 18).
  - in_ready drops in the same cycle the last element is accepted (registered look-ahead).
  - No further element is accepted.
  - in_ready=0 in all other states; in_valid is then ignored.
- CLEAR: exactly 1 cycle with clear_mem=1.
- STREAM:
  - For k=0..n_w+n_x-1 (one per cycle, no gaps), mem_data_in=buf[k].
  - Host back-pressure cannot stall this phase.
  - After the last element: mem_data_in=0, go to WAIT_BANK.
- WAIT_BANK: hold until unload_res=1, then go to DRAIN.
- DRAIN:
  - Count DRAIN_CYCLES cycles.
  - On the final cycle, snapshot res_flat into a 9-entry result register, then go to UNLOAD.
  - Later changes on res_flat do not affect output.
- UNLOAD:
  - Iterate r=0..row_w-1, c=0..col_x-1, row-major.
  - out_valid=1; out_data=snap[r*3+c], out_row=r, out_col=c.
  - Outputs are held stable until out_valid&out_ready, then advance next cycle.
  - out_last=1 on the word (row_w-1, col_x-1).
  - Handshake on the last word → FINISH.
- FINISH: done=1 for 1 cycle, go to IDLE. done and err are never high in the same cycle.
- Counters: element counter 5-bit, result index 2+2 bits, drain counter ceil(log2(DRAIN_CYCLES+1)) bits. None wraps; each resets on state entry.
- Unused MAC entries (r≥row_w or c≥col_x) are never output.

Optional Feature:
MATMUL_DIM_CHECK_EN
- Defined: CHECK rejects a job if any dimension is 0 or col_w≠row_x.
  - Rejection: err pulses 1 cycle, return to IDLE.
  - No in_ready, no clear_mem, bank untouched.
- Not defined: err is tied 0. Every job proceeds with the latched dimensions.
  - If n_w+n_x=0, COLLECT and STREAM last 1 cycle each with no data accepted or driven.
  - UNLOAD emits nothing if row_w or col_x is 0 and goes straight to FINISH.

Test Plan:
- Reset: clear_n low for 3 cycles mid-STREAM → busy=0, out_valid=0, clear_mem=1 during reset; next start runs a normal job.
- 3x3 by 3x3: W=1..9, X=identity; in_valid always 1 → 18 elements accepted; clear_mem for 1 cycle then 18 consecutive mem_data_in values 1..9,1,0,0,0,1,0,0,0,1. Model unload_res after 3 cycles; results 1..9 out in order; out_last on (2,2); done 1 cycle later.
- 2x3 by 3x1: W=1..6, X=2,2,2 → 9 elements accepted; 2 outputs: (0,0)=12, (1,0)=30; out_last on second.
- Back-pressure: toggle out_ready 1/0 every cycle during UNLOAD → each word held stable until accepted; no word lost or duplicated.
- Input gaps: in_valid low on alternate cycles in COLLECT → STREAM still emits elements on consecutive cycles; start pulsed mid-job has no effect.
- With MATMUL_DIM_CHECK_EN: start with col_w=2, row_x=3 → err pulse 2 cycles after start, in_ready never 1, clear_mem never 1, busy low again.
